// File: rtl/miner_pkg.sv
// Shared types and constants for the nonce search engine: FSM state encoding,
// hash/nonce widths and the SHA-256 initial hash values.
package miner_pkg;

  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Element 0 is H0.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic logic [NONCE_W-1:0] next_nonce(input logic [NONCE_W-1:0] n);
    return n + 1'b1;
  endfunction

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Link between the nonce dispatcher (master) and the SHA-256 core (slave).
interface nonce_dispatcher_if #(
  parameter int TOTAL_SIZE = 640
);
  logic [TOTAL_SIZE-1:0] inputMsg;
  logic                  beginComputation;
  logic                  computationComplete;
  logic [255:0]          SHAoutput;

  modport master (
    output inputMsg,
    output beginComputation,
    input  computationComplete,
    input  SHAoutput
  );

  modport slave (
    input  inputMsg,
    input  beginComputation,
    output computationComplete,
    output SHAoutput
  );
endinterface

// File: rtl/target_comparator.sv
// Difficulty test: a hash qualifies when it is numerically <= the target
// (unsigned, bit 255 most significant).
module target_comparator
  import miner_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              hit
);
  assign hit = (hash <= target);
endmodule

// File: rtl/nonce_dispatcher.sv
// Walks a nonce range through an external SHA-256 core and stops on the first
// hash meeting the target. Define HASH_COUNT_EN to add the hash_count output.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int TOTAL_SIZE = 640
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [TOTAL_SIZE-1:0] header,
  input  logic [HASH_W-1:0]     target,
  input  logic [NONCE_W-1:0]    nonce_start,
  input  logic [NONCE_W-1:0]    nonce_end,
  input  logic                  abort,
  nonce_dispatcher_if.master    sha,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  exhausted,
  output logic [NONCE_W-1:0]    golden_nonce,
  output logic [HASH_W-1:0]     golden_hash
`ifdef HASH_COUNT_EN
  ,
  output logic [31:0]           hash_count
`endif
);

  state_t state_reg, state_next;

  logic [TOTAL_SIZE-1:NONCE_W] header_reg;
  logic [HASH_W-1:0]           target_reg;
  logic [HASH_W-1:0]           hash_reg;
  logic [NONCE_W-1:0]          nonce_reg;
  logic [NONCE_W-1:0]          nonce_end_reg;
  logic                        found_reg;
  logic                        exhausted_reg;
  logic [NONCE_W-1:0]          golden_nonce_reg;
  logic [HASH_W-1:0]           golden_hash_reg;

  logic abort_act;
  logic hit;
  logic last;
  logic unused_header_bits;

  // The nonce field of the incoming header is always overwritten.
  assign unused_header_bits = ^header[NONCE_W-1:0];

  assign abort_act = abort && (state_reg != S_IDLE);
  assign last      = (nonce_reg == nonce_end_reg);

  target_comparator u_cmp (
    .hash   (hash_reg),
    .target (target_reg),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (n_rst) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT:   if (sha.computationComplete) state_next = S_CHECK;
      S_CHECK:  state_next = (hit || last) ? S_DONE : S_LAUNCH;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (abort_act) state_next = S_IDLE;
  end

  always_comb begin
    busy                 = (state_reg != S_IDLE);
    done                 = (state_reg == S_DONE) && !abort;
    sha.beginComputation = (state_reg == S_LAUNCH) && !abort;
  end

  assign sha.inputMsg = {header_reg, nonce_reg};

  always_ff @(posedge clk) begin
    if (n_rst) begin
      header_reg       <= '0;
      target_reg       <= '0;
      hash_reg         <= '0;
      nonce_reg        <= '0;
      nonce_end_reg    <= '0;
      found_reg        <= 1'b0;
      exhausted_reg    <= 1'b0;
      golden_nonce_reg <= '0;
      golden_hash_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            header_reg    <= header[TOTAL_SIZE-1:NONCE_W];
            target_reg    <= target;
            nonce_reg     <= nonce_start;
            nonce_end_reg <= nonce_end;
            found_reg     <= 1'b0;
            exhausted_reg <= 1'b0;
          end
        end
        S_WAIT: begin
          if (sha.computationComplete && !abort) hash_reg <= sha.SHAoutput;
        end
        S_CHECK: begin
          if (!abort) begin
            if (hit) begin
              found_reg        <= 1'b1;
              golden_nonce_reg <= nonce_reg;
              golden_hash_reg  <= hash_reg;
            end else if (last) begin
              exhausted_reg <= 1'b1;
            end else begin
              nonce_reg <= next_nonce(nonce_reg);
            end
          end
        end
        default: ;
      endcase
      // A cancelled search leaves no verdict behind.
      if (abort_act) begin
        found_reg     <= 1'b0;
        exhausted_reg <= 1'b0;
      end
    end
  end

  assign found        = found_reg;
  assign exhausted    = exhausted_reg;
  assign golden_nonce = golden_nonce_reg;
  assign golden_hash  = golden_hash_reg;

`ifdef HASH_COUNT_EN
  logic [31:0] hash_count_reg;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      hash_count_reg <= '0;
    end else if (state_reg == S_IDLE && start) begin
      hash_count_reg <= '0;
    end else if (state_reg == S_WAIT && sha.computationComplete && !abort
                 && hash_count_reg != 32'hFFFF_FFFF) begin
      hash_count_reg <= hash_count_reg + 32'd1;
    end
  end

  assign hash_count = hash_count_reg;
`endif

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Random and directed bench for nonce_dispatcher against a range-walk model
// and a behavioural SHA core with variable latency.
`timescale 1ns/1ps
module tb_nonce_dispatcher;
  localparam int TS = 640;

  logic            clk = 1'b0;
  logic            n_rst, start, abort;
  logic [TS-1:0]   header;
  logic [255:0]    target;
  logic [31:0]     nonce_start, nonce_end;
  logic            busy, done, found, exhausted;
  logic [31:0]     golden_nonce;
  logic [255:0]    golden_hash;
`ifdef HASH_COUNT_EN
  logic [31:0]     hash_count;
`endif

  nonce_dispatcher_if #(.TOTAL_SIZE(TS)) sif ();

  nonce_dispatcher #(.TOTAL_SIZE(TS)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .header(header), .target(target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort), .sha(sif),
    .busy(busy), .done(done), .found(found), .exhausted(exhausted),
    .golden_nonce(golden_nonce), .golden_hash(golden_hash)
`ifdef HASH_COUNT_EN
    , .hash_count(hash_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cycle = 0;
  int cc_cycle = -1;
  bit active = 0;
  bit chk_en = 0;
  int lat_force = 0;
  logic [31:0]      salt = 32'h1234_5678;
  logic [31:0]      exp_q[$];
  logic [31:0]      launch_log[$];
  logic [TS-1:32]   exp_hdr;
  logic             exp_found, exp_exh;
  logic [31:0]      exp_gnonce, exp_count;
  logic [255:0]     exp_ghash;
  logic [TS-1:0]    last_msg;

  task automatic chk(input string name, input logic [TS-1:0] act, input logic [TS-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] hash_of(input logic [31:0] n);
    logic [255:0] h;
    for (int i = 0; i < 8; i++)
      h[i*32 +: 32] = ((n ^ salt) * 32'h9E37_79B1) + (i * 32'h7F4A_7C15);
    h[0] = 1'b1;  // never zero, so target 0 never hits
    return h;
  endfunction

  function automatic logic [TS-1:0] rand_hdr();
    logic [TS-1:0] h;
    for (int i = 0; i < TS/32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  // SHA core model: answers each launch after a random (or forced) latency.
  logic [31:0] core_msg;
  int          core_cnt = 0;
  always @(posedge clk) begin
    sif.computationComplete <= 1'b0;
    if (sif.beginComputation) begin
      core_msg <= sif.inputMsg[31:0];
      core_cnt <= (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
    end else if (core_cnt == 1) begin
      sif.computationComplete <= 1'b1;
      sif.SHAoutput           <= hash_of(core_msg);
      core_cnt                <= 0;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  // Reference: list of nonces the search must visit, and its verdict.
  task automatic build_model(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    logic [31:0] n = s;
    exp_q.delete();
    exp_found = 0; exp_exh = 0; exp_gnonce = 0; exp_ghash = 0;
    for (int i = 0; i < 4096; i++) begin
      exp_q.push_back(n);
      if (hash_of(n) <= t) begin
        exp_found = 1; exp_gnonce = n; exp_ghash = hash_of(n);
        break;
      end
      if (n == e) begin exp_exh = 1; break; end
      n = n + 32'd1;
    end
    exp_count = exp_q.size();
  endtask

  // Per-cycle compare against the model.
  initial begin
    logic [31:0] n;
    forever begin
      @(negedge clk);
      cycle++;
      if (chk_en) begin
        if (!active) begin
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_begin", sif.beginComputation, 0);
        end else begin
          chk("busy", busy, 1);
          if (sif.beginComputation) begin
            if (exp_q.size() == 0) chk("extra_launch", 1, 0);
            else begin
              n = exp_q.pop_front();
              chk("launch_nonce", sif.inputMsg[31:0], n);
            end
            chk("launch_header", sif.inputMsg[TS-1:32], exp_hdr);
            if (cc_cycle >= 0) chk("nonce_overhead", cycle - cc_cycle, 2);
            launch_log.push_back(sif.inputMsg[31:0]);
            last_msg = sif.inputMsg;
          end
          if (sif.computationComplete) begin
            chk("msg_stable", sif.inputMsg, last_msg);
            cc_cycle = cycle;
          end
          if (done) begin
            chk("done_latency", cycle - cc_cycle, 2);
            chk("done_pending", exp_q.size(), 0);
            chk("found", found, exp_found);
            chk("exhausted", exhausted, exp_exh);
            if (exp_found) begin
              chk("golden_nonce", golden_nonce, exp_gnonce);
              chk("golden_hash", golden_hash, exp_ghash);
            end
`ifdef HASH_COUNT_EN
            chk("hash_count", hash_count, exp_count);
`endif
            active = 0;
          end
        end
      end
    end
  end

  // Called at posedge+1; start is sampled on the next edge.
  task automatic begin_search(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    header = rand_hdr(); target = t; nonce_start = s; nonce_end = e;
    exp_hdr = header[TS-1:32];
    build_model(s, e, t);
    launch_log.delete();
    cc_cycle = -1;
    start = 1;
    @(posedge clk); #1;
    start = 0; active = 1;
    // Scramble the inputs; only the values captured at start may matter.
    header = rand_hdr(); target = {8{$urandom}}; nonce_start = $urandom; nonce_end = $urandom;
  endtask

  task automatic run_search(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t, input bit poke);
    int k = 0;
    begin_search(s, e, t);
    if (poke) begin
      @(posedge clk); #1;
      if (active) start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    while (active && k < 2000) begin @(posedge clk); #1; k++; end
    if (active) begin chk("search_timeout", 1, 0); active = 0; end
    repeat (2) begin @(posedge clk); #1; end
    chk("found_hold", found, exp_found);
    chk("exhausted_hold", exhausted, exp_exh);
    $display("[TB] search %08h..%08h launches=%0d found=%0b exhausted=%0b", s, e,
             launch_log.size(), found, exhausted);
  endtask

  initial begin
    logic [255:0] h;
    logic [31:0]  wrap_exp [4];
    logic [31:0]  s, len;
    int           k;
    wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    n_rst = 1; start = 0; abort = 0; header = '0; target = '0; nonce_start = '0; nonce_end = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_found", found, 0);
    chk("rst_exhausted", exhausted, 0); chk("rst_gnonce", golden_nonce, 0);
    chk("rst_ghash", golden_hash, 0); chk("rst_msg", sif.inputMsg, 0);
    chk("rst_begin", sif.beginComputation, 0);
`ifdef HASH_COUNT_EN
    chk("rst_count", hash_count, 0);
`endif
    chk_en = 1;
    n_rst = 0;

    // Any hash meets an all-ones target: a single launch at nonce 5.
    run_search(32'd5, 32'd9, {256{1'b1}}, 0);
    chk("lit_any_found", found, 1);
    chk("lit_any_gnonce", golden_nonce, 32'd5);
    chk("lit_any_launches", launch_log.size(), 1);

    // Target 0: walk 10..12 and exhaust.
    run_search(32'd10, 32'd12, 256'd0, 0);
    chk("lit_ex_found", found, 0);
    chk("lit_ex_exhausted", exhausted, 1);
    chk("lit_ex_launches", launch_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("lit_ex_seq", (i < launch_log.size()) ? launch_log[i] : 32'hDEAD_BEEF, 32'd10 + i);
`ifdef HASH_COUNT_EN
    chk("lit_ex_count", hash_count, 3);
`endif

    // Range wrapping through 0xFFFFFFFF.
    run_search(32'hFFFF_FFFE, 32'h1, 256'd0, 0);
    chk("lit_wrap_len", launch_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("lit_wrap_seq", (i < launch_log.size()) ? launch_log[i] : 32'hDEAD_BEEF, wrap_exp[i]);
    chk("lit_wrap_exhausted", exhausted, 1);

    // Target boundary: hash == target hits, target one below misses.
    h = hash_of(32'd77);
    run_search(32'd77, 32'd77, h, 0);
    chk("lit_eq_found", found, 1);
    chk("lit_eq_ghash", golden_hash, h);
    run_search(32'd77, 32'd77, h - 256'd1, 0);
    chk("lit_lt_found", found, 0);
    chk("lit_lt_exhausted", exhausted, 1);

    // Abort coinciding with computationComplete.
    lat_force = 3;
    begin_search(32'd100, 32'd105, 256'd0);
    k = 0;
    while (!sif.computationComplete && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) chk("abort_wait_timeout", 1, 0);
    abort = 1;
    @(posedge clk); #1;
    abort = 0; active = 0; exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_found", found, 0);
    chk("abort_exhausted", exhausted, 0);
    $display("[TB] abort during WAIT: busy=%0b found=%0b", busy, found);
    repeat (3) @(posedge clk);
    #1;
    lat_force = 0;
    run_search(32'd300, 32'd302, hash_of(32'd301), 0);
    chk("post_abort_gnonce", golden_nonce, exp_gnonce);

    // Reset in WAIT with a late completion from the core.
    lat_force = 20;
    begin_search(32'd200, 32'd210, 256'd0);
    k = 0;
    while (launch_log.size() == 0 && k < 100) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1;
    @(posedge clk); #1;
    n_rst = 0; active = 0; exp_q.delete();
    chk("mid_rst_busy", busy, 0); chk("mid_rst_found", found, 0);
    chk("mid_rst_gnonce", golden_nonce, 0); chk("mid_rst_ghash", golden_hash, 0);
    chk("mid_rst_msg", sif.inputMsg, 0);
`ifdef HASH_COUNT_EN
    chk("mid_rst_count", hash_count, 0);
`endif
    repeat (25) @(posedge clk);
    #1;
    chk("late_cc_busy", busy, 0);
    chk("late_cc_exhausted", exhausted, 0);
    $display("[TB] reset during WAIT: busy=%0b found=%0b", busy, found);
    lat_force = 0;

    // Random searches.
    for (int it = 0; it < 40; it++) begin
      salt = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
      len = $urandom_range(0, 5);
      case ($urandom_range(0, 3))
        0:       h = hash_of(s + $urandom_range(0, 32'(len)));
        1:       h = 256'd0;
        2:       h = {$urandom, 224'd0} | {8{$urandom}};
        default: h = {256{1'b1}};
      endcase
      run_search(s, s + len, h, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
